fp_unit_arbiter: RTL
====================

# fp_unit_arbiter

Two-client arbiter and sequencer for the shared 32-bit floating-point arithmetic pool: two adders (sum1/sum2) and two multipliers (prod1/prod2). The pool is external to the butterfly engine. The arbiter lets the FFT butterfly engine and a second client, such as the magnitude/windowing stage, take turns issuing one full operand set at a time. It drives the pool, waits the pool's fixed latency, captures the results and returns them to the owning client.

## Interface
- `LAT`, default 3: pool latency in cycles from operands stable to results valid; range 1..15.
- `WORD`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-client request, level.
- `ops0`, `ops1`  in  8*WORD  client operand bundles, packed MSB→LSB as {a1,b1,a2,b2,m1,n1,m2,n2}.
- `gnt`  out  2  one-cycle grant pulse, one-hot.
- `done`  out  2  one-cycle result-valid pulse, one-hot.
- `res0`, `res1`  out  4*WORD  per-client result registers, packed {sum1,sum2,prod1,prod2}.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `a1`,`b1`,`a2`,`b2`,`m1`,`n1`,`m2`,`n2`  out  WORD  pool operands, registered.
- `sum1`,`sum2`,`prod1`,`prod2`  in  WORD  pool results.

## Operation
- FSM states:
  - IDLE: if any `req` is high, choose the winner, go to BUSY.
  - BUSY: count `LAT` cycles, then go to DONE.
  - DONE: go to IDLE.
- Winner selection is round-robin on a 1-bit `last` pointer.
  - If only one client requests, it wins.
  - If both request, the client ≠ `last` wins.
  - `last` is updated to the winner at grant.
- At the IDLE→BUSY edge:
  - Register the winner's bundle onto the pool operand outputs.
  - Pulse `gnt[winner]`.
  - Store the owner index.
  - Clear the counter.
- BUSY: operands are held stable and the counter increments. At counter == `LAT`−1, the pool results are sampled into `res[owner]`.
- DONE: `done[owner]` is high for this one cycle. `res[owner]` holds until that client's next done. The other client's `res` is never written.
- Pool operand outputs hold their last value in IDLE and DONE; they do not return to zero.
- `req` is level-sensitive. A client drops `req` the cycle after it sees `gnt`; `req` still high on re-entry to IDLE counts as a new request.
- `ops` is sampled only at grant; later changes have no effect.
- Reset values:
  - `gnt`=0, `done`=0, `busy`=0.
  - `res0`/`res1`=0, all pool operands=0.
  - `last`=1, so client 0 wins the first tie.
  - FSM in IDLE.
- Reset mid-transaction aborts it: no `done`, `res` is cleared.
- Counter width is $clog2(`LAT`+1). No arithmetic is performed on data.

## Timing
- Request seen high in IDLE at cycle t:
  - `gnt` and pool operands are valid at t+1.
  - Results are sampled at the end of t+`LAT`.
  - `res`/`done` are valid at t+`LAT`+1.
  - Back in IDLE at t+`LAT`+2.
- Throughput: one transaction per `LAT`+2 cycles.
- Worst-case wait with both clients continuously requesting: 2·(`LAT`+2) cycles.
- A `req` asserted during BUSY or DONE is serviced at the next IDLE; it is not lost and not double-counted.
- Simultaneous requests in IDLE are resolved in that same cycle; no extra cycle is spent on arbitration.

## Structure
- Package `fp_arb_pkg` holds:
  - `WORD`.
  - State enum IDLE/BUSY/DONE.
  - Bundle field offsets (OP_A1…OP_N2, RES_SUM1…RES_PROD2).
  - Widths of the pack and unpack helpers.
- Sub-module `rr_arb2`: combinational winner select plus the registered `last` pointer. Inputs `req[1:0]` and `advance`; outputs `winner` and `any`.
- The main module contains the FSM, the latency counter, the operand mux and register, and the result demux.

## Test plan
- **Single client 0.** `LAT`=3, `req`=01 at t=0, ops0 a1=0x3F800000 (1.0).
  - Expect `gnt`=01 at t=1 and pool a1=0x3F800000 from t=1.
  - With the model returning sum1=0x40000000 at t=3, expect `done`=01 at t=4 and res0 sum1=0x40000000.
  - Expect `busy` low at t=5.
- **Tie-breaking.** Both `req` high from reset.
  - First grant goes to client 0, the next to client 1, then client 0 again.
  - Grant cycles are t=1, 6, 11.
- **Isolation and operand sampling.**
  - While client 0 is BUSY, change ops0 and raise `req[1]`: pool operands are unchanged and client 1 is granted right after DONE.
  - res0 is unaffected by client 1's result.
- **Stale-request rule.** Client holds `req` high through `done`: expect a second `gnt` to the same client at t+`LAT`+3.
- **Reset mid-BUSY.** Assert `rst` at t=2.
  - Next cycle: `busy`=0, `gnt`=`done`=0, res and pool operands=0.
  - No `done` is ever produced for the aborted transaction.
- **`LAT`=1 boundary.** `done` appears at t+2. Back-to-back grants are 3 cycles apart.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared types and bundle layout for the floating-point pool arbiter.
// Field offsets are word indices; multiply by the word width to get bit positions.
package fp_arb_pkg;

  localparam int WORD      = 32;
  localparam int OPS_WORDS = 8;
  localparam int RES_WORDS = 4;
  localparam int OPS_W     = OPS_WORDS * WORD;
  localparam int RES_W     = RES_WORDS * WORD;

  // Operand bundle {a1,b1,a2,b2,m1,n1,m2,n2}, MSB word first
  localparam int OP_A1 = 7;
  localparam int OP_B1 = 6;
  localparam int OP_A2 = 5;
  localparam int OP_B2 = 4;
  localparam int OP_M1 = 3;
  localparam int OP_N1 = 2;
  localparam int OP_M2 = 1;
  localparam int OP_N2 = 0;

  // Result bundle {sum1,sum2,prod1,prod2}, MSB word first
  localparam int RES_SUM1  = 3;
  localparam int RES_SUM2  = 2;
  localparam int RES_PROD1 = 1;
  localparam int RES_PROD2 = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select with a registered last-winner pointer.
// The pointer resets to client 1 so client 0 takes the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner,
  output logic       any
);
  import fp_arb_pkg::*;

  logic last_q, last_d;

  always_comb begin
    any    = |req;
    winner = (req == 2'b11) ? ~last_q : req[1];
    last_d = advance ? winner : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Sequences two clients onto the shared adder/multiplier pool: grant, hold
// operands for LAT cycles, capture results into the owner's register, pulse done.
module fp_unit_arbiter #(
  parameter int LAT  = 3,
  parameter int WORD = fp_arb_pkg::WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [8*WORD-1:0]   ops0,
  input  logic [8*WORD-1:0]   ops1,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [4*WORD-1:0]   res0,
  output logic [4*WORD-1:0]   res1,
  output logic                busy,
  output logic [WORD-1:0]     a1,
  output logic [WORD-1:0]     b1,
  output logic [WORD-1:0]     a2,
  output logic [WORD-1:0]     b2,
  output logic [WORD-1:0]     m1,
  output logic [WORD-1:0]     n1,
  output logic [WORD-1:0]     m2,
  output logic [WORD-1:0]     n2,
  input  logic [WORD-1:0]     sum1,
  input  logic [WORD-1:0]     sum2,
  input  logic [WORD-1:0]     prod1,
  input  logic [WORD-1:0]     prod2
);
  import fp_arb_pkg::*;

  localparam int            CW       = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic [8*WORD-1:0]     opr_q, opr_d;
  logic [4*WORD-1:0]     res0_q, res1_q;
  logic [4*WORD-1:0]     pool_res;
  logic                  winner, any;
  logic                  grant, capture;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (grant),
    .winner  (winner),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    grant   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d        = BUSY;
          cnt_d          = '0;
          owner_d        = winner;
          gnt_d[winner]  = 1'b1;
          grant          = 1'b1;
        end
      end
      BUSY: begin
        // Pool results are valid in the last counted cycle and captured at its end
        if (cnt_q == CNT_LAST) begin
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
          capture         = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign opr_d    = winner ? ops1 : ops0;
  assign pool_res = {sum1, sum2, prod1, prod2};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Operands load only at grant and otherwise hold, including through IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      opr_q  <= '0;
      res0_q <= '0;
      res1_q <= '0;
    end else begin
      if (grant) begin
        opr_q <= opr_d;
      end
      if (capture && !owner_q) begin
        res0_q <= pool_res;
      end
      if (capture && owner_q) begin
        res1_q <= pool_res;
      end
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign res0 = res0_q;
  assign res1 = res1_q;

  assign a1 = opr_q[OP_A1*WORD +: WORD];
  assign b1 = opr_q[OP_B1*WORD +: WORD];
  assign a2 = opr_q[OP_A2*WORD +: WORD];
  assign b2 = opr_q[OP_B2*WORD +: WORD];
  assign m1 = opr_q[OP_M1*WORD +: WORD];
  assign n1 = opr_q[OP_N1*WORD +: WORD];
  assign m2 = opr_q[OP_M2*WORD +: WORD];
  assign n2 = opr_q[OP_N2*WORD +: WORD];

endmodule
